// File: rtl/hid_report_mux.sv
// Multi-channel HID report queue: per-channel FIFOs, round-robin grant, LSB-first byte stream.
// Define HID_REPORT_ID_EN to prefix each report with an ID byte (channel + 1).
module hid_report_mux #(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned REPORT_BYTES = 4,
  parameter int unsigned DEPTH        = 4,
  localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CH-1:0]                ch_req,
  input  logic [NUM_CH*REPORT_BYTES*8-1:0] ch_data,
  output logic [NUM_CH-1:0]                ch_full,
  output logic [NUM_CH-1:0]                ch_ovf,
  input  logic                             usb_configured,
  output logic [7:0]                       tx_data,
  output logic                             tx_valid,
  input  logic                             tx_ready,
  output logic                             tx_last,
  output logic [CW-1:0]                    tx_ch
);

  localparam int unsigned RW = REPORT_BYTES * 8;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned IW = (REPORT_BYTES > 1) ? $clog2(REPORT_BYTES) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StPayload
`ifdef HID_REPORT_ID_EN
    , StHdr
`endif
  } state_e;

  logic [RW-1:0]   mem_q [NUM_CH][DEPTH];
  logic [AW:0]     wr_ptr_q [NUM_CH];
  logic [AW:0]     rd_ptr_q [NUM_CH];
  logic [NUM_CH-1:0] empty, full, push, pop, ovf_q;

  state_e          state_q, state_d;
  logic [CW-1:0]   ch_q, ch_d, rr_q, rr_d, grant_ch, cand;
  logic            grant_valid, hs, last_byte;
  logic [RW-1:0]   data_q, data_d, head;
  logic [IW-1:0]   idx_q, idx_d;

  assign hs        = usb_configured && (state_q != StIdle) && tx_ready;
  assign last_byte = (idx_q == IW'(REPORT_BYTES - 1));

  always_comb begin
    empty = '0;
    full  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      empty[c] = (wr_ptr_q[c] == rd_ptr_q[c]);
      full[c]  = (wr_ptr_q[c][AW] != rd_ptr_q[c][AW]) &&
                 (wr_ptr_q[c][AW-1:0] == rd_ptr_q[c][AW-1:0]);
    end
  end

  always_comb begin
    pop = '0;
    if (state_q == StPayload && hs && last_byte) pop[ch_q] = 1'b1;
  end

  // A full FIFO still accepts a push in the cycle its head is retired.
  always_comb begin
    push = ch_req & {NUM_CH{usb_configured}} & (~full | pop);
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = CW'((32'(rr_q) + i) % NUM_CH);
      if (!grant_valid && !empty[cand]) begin
        grant_valid = 1'b1;
        grant_ch    = cand;
      end
    end
    head = mem_q[grant_ch][rd_ptr_q[grant_ch][AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (!usb_configured) begin
          wr_ptr_q[c] <= '0;
          rd_ptr_q[c] <= '0;
        end else begin
          if (push[c]) wr_ptr_q[c] <= wr_ptr_q[c] + 1'b1;
          if (pop[c])  rd_ptr_q[c] <= rd_ptr_q[c] + 1'b1;
        end
      end
      ovf_q <= ovf_q | (ch_req & ~push);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (push[c]) mem_q[c][wr_ptr_q[c][AW-1:0]] <= ch_data[c*RW +: RW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ch_q    <= '0;
      rr_q    <= '0;
      data_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      rr_q    <= rr_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    rr_d    = rr_q;
    data_d  = data_q;
    idx_d   = idx_q;
    if (!usb_configured) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_valid) begin
            ch_d   = grant_ch;
            data_d = head;
            idx_d  = '0;
`ifdef HID_REPORT_ID_EN
            state_d = StHdr;
`else
            state_d = StPayload;
`endif
          end
        end
`ifdef HID_REPORT_ID_EN
        StHdr: begin
          if (hs) state_d = StPayload;
        end
`endif
        StPayload: begin
          if (hs) begin
            if (last_byte) begin
              rr_d    = (ch_q == CW'(NUM_CH - 1)) ? '0 : ch_q + CW'(1);
              state_d = StIdle;
            end else begin
              data_d = data_q >> 8;
              idx_d  = idx_q + IW'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    tx_valid = usb_configured && (state_q != StIdle);
    tx_last  = usb_configured && (state_q == StPayload) && last_byte;
    tx_data  = '0;
    if (tx_valid) begin
`ifdef HID_REPORT_ID_EN
      tx_data = (state_q == StHdr) ? (8'(ch_q) + 8'd1) : data_q[7:0];
`else
      tx_data = data_q[7:0];
`endif
    end
    tx_ch   = ch_q;
    ch_full = full & {NUM_CH{usb_configured}};
    ch_ovf  = ovf_q;
  end

endmodule

// File: tb/tb_hid_report_mux.sv
// Randomised bench for hid_report_mux against a queue-based transaction model.
module tb_hid_report_mux;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned RB     = 4;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned RW     = RB * 8;
  localparam int unsigned DW     = NUM_CH * RW;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] ch_req;
  logic [DW-1:0]     ch_data;
  logic [NUM_CH-1:0] ch_full, ch_ovf;
  logic              usb_configured;
  logic [7:0]        tx_data;
  logic              tx_valid, tx_ready, tx_last;
  logic [0:0]        tx_ch;

  hid_report_mux #(
    .NUM_CH      (NUM_CH),
    .REPORT_BYTES(RB),
    .DEPTH       (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ch_req        (ch_req),
    .ch_data       (ch_data),
    .ch_full       (ch_full),
    .ch_ovf        (ch_ovf),
    .usb_configured(usb_configured),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_last       (tx_last),
    .tx_ch         (tx_ch)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: queued reports per channel, plus the byte list of the report on the wire.
  logic [RW-1:0]     mq [NUM_CH][$];
  logic [7:0]        cur_bytes[$];
  int                cur_ch;
  bit                busy;
  int                rr;
  logic [NUM_CH-1:0] m_ovf;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) mq[c].delete();
    cur_bytes.delete();
    busy   = 0;
    rr     = 0;
    cur_ch = 0;
    m_ovf  = '0;
  endtask

  task automatic compare_outputs(input logic cfg);
    logic              exp_valid;
    logic [NUM_CH-1:0] exp_full;
    exp_valid = cfg && busy;
    check_eq("tx_valid", tx_valid, exp_valid);
    if (exp_valid) begin
      check_eq("tx_data", tx_data, cur_bytes[0]);
      check_eq("tx_last", tx_last, cur_bytes.size() == 1);
      check_eq("tx_ch", tx_ch, cur_ch);
    end else begin
      check_eq("tx_last_idle", tx_last, 0);
    end
    for (int c = 0; c < NUM_CH; c++) exp_full[c] = cfg && (mq[c].size() == DEPTH);
    check_eq("ch_full", ch_full, exp_full);
    check_eq("ch_ovf", ch_ovf, m_ovf);
  endtask

  task automatic model_step(input logic [NUM_CH-1:0] req, input logic [DW-1:0] data,
                            input logic cfg, input logic rdy);
    bit found;
    int c;
    logic [RW-1:0] p;
    if (!cfg) begin
      m_ovf |= req;
      for (int k = 0; k < NUM_CH; k++) mq[k].delete();
      cur_bytes.delete();
      busy = 0;
      return;
    end
    if (busy) begin
      if (rdy) begin
        void'(cur_bytes.pop_front());
        if (cur_bytes.size() == 0) begin
          void'(mq[cur_ch].pop_front());
          rr   = (cur_ch + 1) % NUM_CH;
          busy = 0;
        end
      end
    end else begin
      found = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        c = (rr + i) % NUM_CH;
        if (!found && mq[c].size() > 0) begin
          found  = 1;
          busy   = 1;
          cur_ch = c;
          p      = mq[c][0];
`ifdef HID_REPORT_ID_EN
          cur_bytes.push_back(8'(c + 1));
`endif
          for (int k = 0; k < RB; k++) cur_bytes.push_back(8'(p >> (8 * k)));
        end
      end
    end
    // A retirement above has already freed its slot for a same-cycle push.
    for (int k = 0; k < NUM_CH; k++) begin
      if (req[k]) begin
        if (mq[k].size() < DEPTH) mq[k].push_back(data[k*RW +: RW]);
        else m_ovf[k] = 1'b1;
      end
    end
  endtask

  task automatic cycle(input logic [NUM_CH-1:0] req, input logic [DW-1:0] data,
                       input logic cfg, input logic rdy);
    ch_req         = req;
    ch_data        = data;
    usb_configured = cfg;
    tx_ready       = rdy;
    @(negedge clk);
    compare_outputs(cfg);
    model_step(req, data, cfg, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) cycle('0, '0, 1'b1, rdy);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < NUM_CH; i++) d[i*RW +: RW] = RW'($urandom);
    return d;
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, tx_valid, 0);
    check_eq({tag, "_data"}, tx_data, 0);
    check_eq({tag, "_last"}, tx_last, 0);
    check_eq({tag, "_ch"}, tx_ch, 0);
    check_eq({tag, "_full"}, ch_full, 0);
    check_eq({tag, "_ovf"}, ch_ovf, 0);
  endtask

  initial begin
    rst            = 1'b1;
    ch_req         = '0;
    ch_data        = '0;
    usb_configured = 1'b1;
    tx_ready       = 1'b0;
    #1;
    check_all_zero("reset");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single report, free-flowing sink.
    cycle(2'b01, {32'h0, 32'h4433_2211}, 1'b1, 1'b1);
    idle(8, 1'b1);

    // Both channels push three reports back to back.
    repeat (3) cycle(2'b11, rnd_data(), 1'b1, 1'b1);
    idle(30, 1'b1);

    // Sink stalls for ten cycles on the third byte.
    cycle(2'b01, rnd_data(), 1'b1, 1'b1);
    repeat (3) cycle('0, '0, 1'b1, 1'b1);
    repeat (10) cycle('0, '0, 1'b1, 1'b0);
    idle(8, 1'b1);

    // Five pushes into a depth-four FIFO with the sink blocked.
    repeat (5) cycle(2'b01, rnd_data(), 1'b1, 1'b0);
    check_eq("ovf_ch0", ch_ovf[0], 1);
    check_eq("ovf_ch1", ch_ovf[1], 0);
    check_eq("full_ch0", ch_full[0], 1);
    idle(30, 1'b1);

    // Deconfigure mid-report with reports queued on both channels.
    repeat (2) cycle(2'b11, rnd_data(), 1'b1, 1'b1);
    repeat (3) cycle('0, '0, 1'b1, 1'b1);
    repeat (2) cycle('0, '0, 1'b0, 1'b1);
    idle(10, 1'b1);

    // Random traffic with occasional deconfiguration.
    for (int n = 0; n < 3000; n++) begin
      logic [NUM_CH-1:0] req;
      for (int c = 0; c < NUM_CH; c++) req[c] = ($urandom_range(99) < 30);
      cycle(req, rnd_data(), ($urandom_range(99) >= 2), ($urandom_range(99) < 70));
    end

    // Asynchronous reset in the middle of a report.
    cycle(2'b11, rnd_data(), 1'b1, 1'b1);
    repeat (3) cycle('0, '0, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    idle(10, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
